l2_fifo_p: RTL and testbench

Parametrised synchronous single-clock FIFO, the next generation of the L2 32×32 buffer. It adds configurable width and depth, a fill-level output, programmable almost-full/almost-empty thresholds, sticky overflow/underflow flags, and a selectable first-word-fall-through (FWFT) read mode. It sits between the SPI word assembler and the downstream L2 consumer, and is a drop-in for existing L2 buffering when `FWFT=0`, `DW=32`, `AW=5`.

---
 rtl/l2_fifo_pkg.sv | 17 +
 rtl/l2_fifo_mem.sv | 27 ++
 rtl/l2_fifo_p.sv | 119 +++++++++++
 tb/tb_l2_fifo_p.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/l2_fifo_pkg.sv
// Shared defaults and reset constants for the L2 parametrised FIFO.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package l2_fifo_pkg;

    localparam int DEF_DW = 32;
    localparam int DEF_AW = 5;

    // The level counter must represent 0..DEPTH inclusive, hence one extra bit.
    function automatic int level_w(input int aw);
        return aw + 1;
    endfunction

    localparam logic RST_FLAG     = 1'b0;
    localparam logic RST_DOUT_BIT = 1'b0;

endpackage

// File: rtl/l2_fifo_mem.sv
// DEPTH x DW register array: one synchronous write port, one asynchronous read port.
// Latency: write visible on the read port the cycle after we; read is combinational.
// Backpressure: none; the caller qualifies we.
module l2_fifo_mem #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // Storage is deliberately not reset; the FIFO pointers define what is valid.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/l2_fifo_p.sv
// Parametrised single-clock FIFO with level, thresholds, sticky ovf/udf and optional FWFT read.
// Latency: FWFT=0 dout valid 1 cycle after an accepted rd; FWFT=1 head word visible 1 cycle after write.
// Backpressure: none; writes while full are dropped (ovf), reads while empty are ignored (udf).
module l2_fifo_p
    import l2_fifo_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int AW    = DEF_AW,
    parameter int AF_TH = 2**AW - 2,
    parameter int AE_TH = 2,
    parameter int FWFT  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  wr,
    input  logic [DW-1:0]         din,
    input  logic                  rd,
    output logic [DW-1:0]         dout,
    output logic                  empty,
    output logic                  full,
    output logic [level_w(AW)-1:0] level,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  ovf,
    output logic                  udf
);

    localparam int              LW      = level_w(AW);
    localparam logic [LW-1:0]   DEPTH_L = LW'(2**AW);
    localparam logic [LW-1:0]   AF_L    = LW'(AF_TH);
    localparam logic [LW-1:0]   AE_L    = LW'(AE_TH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic          ovf_q;
    logic          udf_q;
    logic          wa;
    logic          ra;
    logic          flush;
    logic [DW-1:0] head;

    // Everything below is a pure decode of the level register.
    assign empty        = (level_q == '0);
    assign full         = (level_q == DEPTH_L);
    assign almost_full  = (level_q >= AF_L);
    assign almost_empty = (level_q <= AE_L);
    assign level        = level_q;
    assign ovf          = ovf_q;
    assign udf          = udf_q;

    // rst and clr both override any traffic in the same cycle.
    assign flush = rst | clr;
    assign wa    = wr & ~full  & ~flush;
    assign ra    = rd & ~empty & ~flush;

    l2_fifo_mem #(
        .DW (DW),
        .AW (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wa),
        .waddr (wr_ptr),
        .wdata (din),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Pointers, level counter and sticky error flags.
    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            ovf_q   <= RST_FLAG;
            udf_q   <= RST_FLAG;
        end else begin
            if (wa) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (ra) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({wa, ra})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
            if (wr && full) begin
                ovf_q <= 1'b1;
            end
            if (rd && empty) begin
                udf_q <= 1'b1;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word shown directly; forced to zero when nothing is stored.
            assign dout = empty ? '0 : head;
        end else begin : g_reg
            logic [DW-1:0] dout_q;

            // Registered read: capture the head word on each accepted pop, hold otherwise.
            always_ff @(posedge clk) begin
                if (flush) begin
                    dout_q <= {DW{RST_DOUT_BIT}};
                end else if (ra) begin
                    dout_q <= head;
                end
            end

            assign dout = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_l2_fifo_p.sv
// Randomized scoreboard bench for l2_fifo_p: default registered instance and a small FWFT instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_l2_fifo_p;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;

    logic        wr_a = 1'b0, rd_a = 1'b0;
    logic [31:0] din_a = '0, dout_a;
    logic        empty_a, full_a, af_a, ae_a, ovf_a, udf_a;
    logic [5:0]  level_a;

    logic        wr_b = 1'b0, rd_b = 1'b0;
    logic [7:0]  din_b = '0, dout_b;
    logic        empty_b, full_b, af_b, ae_b, ovf_b, udf_b;
    logic [2:0]  level_b;

    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    // Reference model state: stored words and expected sticky flags.
    logic [31:0] qa[$];
    logic [31:0] sb_a[$];
    logic        m_ovf_a = 1'b0, m_udf_a = 1'b0;
    logic [7:0]  qb[$];
    logic        m_ovf_b = 1'b0, m_udf_b = 1'b0;

    always #5 clk = ~clk;

    l2_fifo_p u_dut_a (
        .clk (clk), .rst (rst), .clr (clr),
        .wr (wr_a), .din (din_a), .rd (rd_a), .dout (dout_a),
        .empty (empty_a), .full (full_a), .level (level_a),
        .almost_full (af_a), .almost_empty (ae_a), .ovf (ovf_a), .udf (udf_a)
    );

    l2_fifo_p #(.DW(8), .AW(2), .FWFT(1)) u_dut_b (
        .clk (clk), .rst (rst), .clr (clr),
        .wr (wr_b), .din (din_b), .rd (rd_b), .dout (dout_b),
        .empty (empty_b), .full (full_b), .level (level_b),
        .almost_full (af_b), .almost_empty (ae_b), .ovf (ovf_b), .udf (udf_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model for the registered instance: popped words become the next expected dout.
    always @(posedge clk) begin : model_a
        automatic int sz;
        sz = qa.size();
        if (rst || clr) begin
            qa.delete();
            sb_a.delete();
            sb_a.push_back(32'h0);
            m_ovf_a <= 1'b0;
            m_udf_a <= 1'b0;
        end else begin
            if (wr_a && sz == 32) m_ovf_a <= 1'b1;
            if (rd_a && sz == 0)  m_udf_a <= 1'b1;
            if (rd_a && sz != 0)  sb_a.push_back(qa.pop_front());
            if (wr_a && sz != 32) qa.push_back(din_a);
        end
    end

    // Model for the FWFT instance.
    always @(posedge clk) begin : model_b
        automatic int sz;
        sz = qb.size();
        if (rst || clr) begin
            qb.delete();
            m_ovf_b <= 1'b0;
            m_udf_b <= 1'b0;
        end else begin
            if (wr_b && sz == 4) m_ovf_b <= 1'b1;
            if (rd_b && sz == 0) m_udf_b <= 1'b1;
            if (rd_b && sz != 0) void'(qb.pop_front());
            if (wr_b && sz != 4) qb.push_back(din_b);
        end
    end

    // Monitor: compare all outputs mid-cycle against the model.
    always @(negedge clk) begin
        if (mon_en) begin
            while (sb_a.size() > 1) void'(sb_a.pop_front());
            chk("a_dout",  dout_a, sb_a[0]);
            chk("a_level", 32'(level_a), 32'(qa.size()));
            chk("a_empty", 32'(empty_a), 32'(qa.size() == 0));
            chk("a_full",  32'(full_a),  32'(qa.size() == 32));
            chk("a_af",    32'(af_a),    32'(qa.size() >= 30));
            chk("a_ae",    32'(ae_a),    32'(qa.size() <= 2));
            chk("a_ovf",   32'(ovf_a),   32'(m_ovf_a));
            chk("a_udf",   32'(udf_a),   32'(m_udf_a));

            chk("b_dout",  32'(dout_b),  (qb.size() > 0) ? 32'(qb[0]) : 32'h0);
            chk("b_level", 32'(level_b), 32'(qb.size()));
            chk("b_empty", 32'(empty_b), 32'(qb.size() == 0));
            chk("b_full",  32'(full_b),  32'(qb.size() == 4));
            chk("b_af",    32'(af_b),    32'(qb.size() >= 2));
            chk("b_ae",    32'(ae_b),    32'(qb.size() <= 2));
            chk("b_ovf",   32'(ovf_b),   32'(m_ovf_b));
            chk("b_udf",   32'(udf_b),   32'(m_udf_b));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op_a(input logic w, input logic r, input logic [31:0] d);
        wr_a = w; rd_a = r; din_a = d;
        tick();
        wr_a = 1'b0; rd_a = 1'b0;
    endtask

    task automatic op_b(input logic w, input logic r, input logic [7:0] d);
        wr_b = w; rd_b = r; din_b = d;
        tick();
        wr_b = 1'b0; rd_b = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        mon_en = 1'b1;
        tick();

        // Fill to full with 1..32, then wr+rd at full, drain, wr+rd at empty.
        for (int i = 1; i <= 32; i++) op_a(1'b1, 1'b0, 32'(i));
        op_a(1'b1, 1'b1, 32'hDEAD);
        for (int i = 0; i < 31; i++) op_a(1'b0, 1'b1, 32'h0);
        op_a(1'b0, 1'b0, 32'h0);
        op_a(1'b1, 1'b1, 32'h77);
        op_a(1'b0, 1'b1, 32'h0);
        op_a(1'b0, 1'b1, 32'h0);
        clr = 1'b1; tick(); clr = 1'b0;

        // Pointer wrap-around.
        for (int i = 0; i < 20; i++) op_a(1'b1, 1'b0, 32'h100 + 32'(i));
        for (int i = 0; i < 20; i++) op_a(1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 20; i++) op_a(1'b1, 1'b0, 32'hA0 + 32'(i));
        for (int i = 0; i < 20; i++) op_a(1'b0, 1'b1, 32'h0);

        // Steady state at level 10 with simultaneous traffic.
        for (int i = 0; i < 10; i++) op_a(1'b1, 1'b0, $urandom);
        for (int i = 0; i < 50; i++) op_a(1'b1, 1'b1, $urandom);
        for (int i = 0; i < 10; i++) op_a(1'b0, 1'b1, 32'h0);

        // clr together with a write at level 7, with udf set beforehand.
        op_a(1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 7; i++) op_a(1'b1, 1'b0, 32'h200 + 32'(i));
        clr = 1'b1; op_a(1'b1, 1'b0, 32'hBAD); clr = 1'b0;
        op_a(1'b0, 1'b0, 32'h0);

        // rst mid-burst at level 12, then a fresh word comes out first.
        for (int i = 0; i < 12; i++) op_a(1'b1, 1'b0, 32'h300 + 32'(i));
        rst = 1'b1; op_a(1'b1, 1'b1, 32'hBAD); rst = 1'b0;
        op_a(1'b1, 1'b0, 32'h1234);
        op_a(1'b0, 1'b1, 32'h0);
        op_a(1'b0, 1'b0, 32'h0);

        // Random traffic on the registered instance with occasional flushes.
        for (int i = 0; i < 800; i++) begin
            clr = ($urandom_range(0, 199) == 0);
            rst = ($urandom_range(0, 299) == 0);
            op_a($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, $urandom);
        end
        clr = 1'b0; rst = 1'b0;
        clr = 1'b1; tick(); clr = 1'b0;

        // FWFT: word appears without rd, pop empties it, then overfill/underflow.
        op_b(1'b1, 1'b0, 8'h5A);
        op_b(1'b0, 1'b0, 8'h0);
        op_b(1'b0, 1'b1, 8'h0);
        op_b(1'b0, 1'b0, 8'h0);
        for (int i = 0; i < 5; i++) op_b(1'b1, 1'b0, 8'(8'h10 + i));
        op_b(1'b1, 1'b1, 8'h99);
        for (int i = 0; i < 5; i++) op_b(1'b0, 1'b1, 8'h0);
        op_b(1'b1, 1'b1, 8'h42);
        clr = 1'b1; tick(); clr = 1'b0;
        for (int i = 0; i < 400; i++) begin
            clr = ($urandom_range(0, 149) == 0);
            op_b($urandom_range(0, 99) < 50, $urandom_range(0, 99) < 50, 8'($urandom));
        end
        clr = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
